// File: rtl/mips_pkg.sv
// Shared opcodes, ALU/mux select codes, FSM state encodings and control word for the multicycle MIPS controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state + mem_ready -> control word decoder; zero latency.
// mem_ready gates only the FETCH IR/PC load and the store retirement pulse.
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            // Branch target is precomputed into ALUOut while the opcode is decoded.
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with retired-instruction counter.
// 3-5 cycles per instruction; stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl;
    logic       mem_rdy;
    logic [CNT_W-1:0] count_q;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_rdy ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_INIT;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_rdy),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (ctrl.instr_done) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = (state_q == S_DECODE) && !op_legal(opcode);
    assign instr_count   = count_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed table-driven bench for mips_multicycle_ctrl (4-bit counter to reach the wrap).
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, instr_done;
    logic [3:0] instr_count;
    logic [3:0] state_dbg;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.CNT_W(4), .USE_MEM_READY(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done),
        .instr_count   (instr_count),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: pw pwc iord mr mw irw m2r rdst rw asa | asb aop psrc | ill done
    logic [17:0] act_w;
    assign act_w = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a,
                    alu_src_b, alu_op, pc_source, illegal_op, instr_done};

    localparam logic [17:0] W_ZERO   = 18'd0;
    localparam logic [17:0] W_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_FSTALL = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b00,2'b00, 1'b1,1'b0};
    localparam logic [17:0] W_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_MREAD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1};
    localparam logic [17:0] W_MWR0   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_MWR1   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1};
    localparam logic [17:0] W_REXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b10,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1};
    localparam logic [17:0] W_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b01,2'b01, 1'b0,1'b1};
    localparam logic [17:0] W_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b10, 1'b0,1'b1};
    localparam logic [17:0] W_AEXEC  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b00, 1'b0,1'b0};
    localparam logic [17:0] W_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00, 1'b0,1'b1};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] w;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [17:0] w, input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.w = w; v.cnt = cnt;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are applied at the falling edge and outputs sampled 1ns later.
    task automatic cycle(input string tag, input logic [5:0] op, input logic rdy,
                         input logic [3:0] st, input logic [17:0] w, input logic [3:0] cnt);
        opcode    = op;
        mem_ready = rdy;
        #1;
        chk({tag, ".state"}, 32'(state_dbg), 32'(st));
        chk({tag, ".ctrl"},  32'(act_w),     32'(w));
        chk({tag, ".count"}, 32'(instr_count), 32'(cnt));
        @(negedge clk);
    endtask

    logic [3:0] model_cnt;
    logic       saw_15;
    logic       saw_wrap;

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'h00;
        mem_ready = 1'b1;

        // R-type: 1,2,7,8
        add(6'h00, 1'b1, 4'd0,  W_ZERO,  4'd0);
        add(6'h00, 1'b1, 4'd1,  W_FETCH, 4'd0);
        add(6'h00, 1'b1, 4'd2,  W_DEC,   4'd0);
        add(6'h00, 1'b1, 4'd7,  W_REXEC, 4'd0);
        add(6'h00, 1'b1, 4'd8,  W_RWB,   4'd0);
        // lw with two wait cycles: 1,2,3,4,4,4,5
        add(6'h23, 1'b1, 4'd1,  W_FETCH, 4'd1);
        add(6'h23, 1'b1, 4'd2,  W_DEC,   4'd1);
        add(6'h23, 1'b1, 4'd3,  W_MADDR, 4'd1);
        add(6'h23, 1'b0, 4'd4,  W_MREAD, 4'd1);
        add(6'h23, 1'b0, 4'd4,  W_MREAD, 4'd1);
        add(6'h23, 1'b1, 4'd4,  W_MREAD, 4'd1);
        add(6'h23, 1'b1, 4'd5,  W_MWB,   4'd1);
        // sw with one wait cycle in MEM_WRITE
        add(6'h2B, 1'b1, 4'd1,  W_FETCH, 4'd2);
        add(6'h2B, 1'b1, 4'd2,  W_DEC,   4'd2);
        add(6'h2B, 1'b1, 4'd3,  W_MADDR, 4'd2);
        add(6'h2B, 1'b0, 4'd6,  W_MWR0,  4'd2);
        add(6'h2B, 1'b1, 4'd6,  W_MWR1,  4'd2);
        // beq
        add(6'h04, 1'b1, 4'd1,  W_FETCH, 4'd3);
        add(6'h04, 1'b1, 4'd2,  W_DEC,   4'd3);
        add(6'h04, 1'b1, 4'd9,  W_BR,    4'd3);
        // j
        add(6'h02, 1'b1, 4'd1,  W_FETCH, 4'd4);
        add(6'h02, 1'b1, 4'd2,  W_DEC,   4'd4);
        add(6'h02, 1'b1, 4'd10, W_JMP,   4'd4);
        // illegal opcode, then a stalled fetch
        add(6'h3F, 1'b1, 4'd1,  W_FETCH,  4'd5);
        add(6'h3F, 1'b1, 4'd2,  W_DECILL, 4'd5);
        add(6'h3F, 1'b0, 4'd1,  W_FSTALL, 4'd5);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("reset.state", 32'(state_dbg), 32'd0);
            chk("reset.ctrl",  32'(act_w),     32'd0);
            chk("reset.count", 32'(instr_count), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            cycle($sformatf("vec%0d", i), tv[i].op, tv[i].rdy, tv[i].st, tv[i].w, tv[i].cnt);
        end

        // 16 addi instructions: counter must pass 15 and wrap to 0
        model_cnt = 4'd5;
        saw_15    = 1'b0;
        saw_wrap  = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cycle($sformatf("addi%0d.f", n), 6'h08, 1'b1, 4'd1,  W_FETCH, model_cnt);
            cycle($sformatf("addi%0d.d", n), 6'h08, 1'b1, 4'd2,  W_DEC,   model_cnt);
            cycle($sformatf("addi%0d.e", n), 6'h08, 1'b1, 4'd11, W_AEXEC, model_cnt);
            cycle($sformatf("addi%0d.w", n), 6'h08, 1'b1, 4'd12, W_AWB,   model_cnt);
            if (model_cnt == 4'd15) saw_15 = 1'b1;
            model_cnt = model_cnt + 4'd1;
            if (model_cnt == 4'd0 && saw_15) saw_wrap = 1'b1;
        end
        chk("wrap.seen", 32'({saw_15, saw_wrap}), 32'b11);

        // Reset in the middle of ADDI_EXEC aborts without retiring
        cycle("abort.f", 6'h08, 1'b1, 4'd1, W_FETCH, model_cnt);
        cycle("abort.d", 6'h08, 1'b1, 4'd2, W_DEC,   model_cnt);
        opcode = 6'h08;
        #1;
        chk("abort.pre_state", 32'(state_dbg), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.state", 32'(state_dbg),   32'd0);
        chk("abort.ctrl",  32'(act_w),       32'd0);
        chk("abort.count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("restart.init",  6'h00, 1'b1, 4'd0, W_ZERO,  4'd0);
        cycle("restart.fetch", 6'h00, 1'b1, 4'd1, W_FETCH, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
